countdown_timer_ctrl: RTL and testbench

// - Sequencing controller for the MM:SS display path: owns the three BCD digits (Minutos, DezenaSeg, UnidadeSeg) that feed the 7-segment decoder.
// - Accepts keypad digit entry, then start/stop/clear commands; counts down once per second and gates the heater (MagnetronOn).
// - Sits between keypad/door inputs and the display decoder inside the nivel1 top.

---
 rtl/countdown_timer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown sequencer: keypad digit entry, start/stop/clear, 1 s decrement, heater gate.
// Optional QUICK_START_EN: Start at 0:00 in IDLE loads 0:QUICK_SECS and runs.
module countdown_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned QUICK_SECS    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KeyValid,
  input  logic [3:0] KeyDigit,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic       DoorClosed,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] UnidadeSeg,
  output logic       MagnetronOn,
  output logic       Done
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    dez_q, dez_d;
  logic [3:0]    uni_q, uni_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mag_q, mag_d;
  logic          done_q, done_d;

  logic hold;
  logic key_ok;
  logic time_zero;
  logic last_sec;

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    dez_d     = dez_q;
    uni_d     = uni_q;
    presc_d   = presc_q;
    hold      = Stop | ~DoorClosed;
    key_ok    = KeyValid && (KeyDigit <= 4'd9) && (uni_q <= 4'd5);
    time_zero = (min_q == '0) && (dez_q == '0) && (uni_q == '0);
    last_sec  = (min_q == '0) && (dez_q == '0) && (uni_q == 4'd1);

    unique case (state_q)
      S_IDLE: begin
        if (Clear) begin
          min_d = '0;
          dez_d = '0;
          uni_d = '0;
        end else if (hold) begin
          state_d = S_IDLE;
        end else if (Start) begin
          if (!time_zero) begin
            state_d = S_RUN;
            presc_d = '0;
          end
`ifdef QUICK_START_EN
          else begin
            state_d = S_RUN;
            presc_d = '0;
            min_d   = '0;
            dez_d   = 4'(QUICK_SECS / 10);
            uni_d   = 4'(QUICK_SECS % 10);
          end
`endif
        end else if (key_ok) begin
          min_d = dez_q;
          dez_d = uni_q;
          uni_d = KeyDigit;
        end
      end

      S_RUN: begin
        if (Clear) begin
          state_d = S_IDLE;
          min_d   = '0;
          dez_d   = '0;
          uni_d   = '0;
        end else if (hold) begin
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          // Borrow chain; time is never 0:00 in RUN, so minutes cannot underflow.
          if (uni_q != '0) begin
            uni_d = uni_q - 4'd1;
          end else begin
            uni_d = 4'd9;
            if (dez_q != '0) begin
              dez_d = dez_q - 4'd1;
            end else begin
              dez_d = 4'd5;
              min_d = min_q - 4'd1;
            end
          end
          if (last_sec) state_d = S_DONE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      S_PAUSE: begin
        if (Clear) begin
          state_d = S_IDLE;
          min_d   = '0;
          dez_d   = '0;
          uni_d   = '0;
        end else if (hold) begin
          state_d = S_PAUSE;
        end else if (Start) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (Clear) begin
          state_d = S_IDLE;
        end else if (hold) begin
          state_d = S_DONE;
        end else if (Start || KeyValid) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    mag_d  = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      min_q   <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
      presc_q <= '0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      dez_q   <= dez_d;
      uni_q   <= uni_d;
      presc_q <= presc_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  assign Minutos     = min_q;
  assign DezenaSeg   = dez_q;
  assign UnidadeSeg  = uni_q;
  assign MagnetronOn = mag_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICKS_PER_SEC=4; expected values hand-computed.
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       KeyValid = 1'b0;
  logic [3:0] KeyDigit = '0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       Clear = 1'b0;
  logic       DoorClosed = 1'b1;
  logic [3:0] Minutos, DezenaSeg, UnidadeSeg;
  logic       MagnetronOn, Done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  countdown_timer_ctrl #(.TICKS_PER_SEC(4), .QUICK_SECS(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .KeyValid   (KeyValid),
    .KeyDigit   (KeyDigit),
    .Start      (Start),
    .Stop       (Stop),
    .Clear      (Clear),
    .DoorClosed (DoorClosed),
    .Minutos    (Minutos),
    .DezenaSeg  (DezenaSeg),
    .UnidadeSeg (UnidadeSeg),
    .MagnetronOn(MagnetronOn),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    KeyValid = 1'b1;
    KeyDigit = d;
    cyc(1);
    KeyValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    cyc(1);
    Clear = 1'b0;
  endtask

  function automatic logic [11:0] disp();
    return {Minutos, DezenaSeg, UnidadeSeg};
  endfunction

  initial begin
    cyc(2);
    reset = 1'b0;
    check_eq("reset_digits", disp(), 12'h000);
    check_eq("reset_mag", {11'd0, MagnetronOn}, 12'h000);
    check_eq("reset_done", {11'd0, Done}, 12'h000);

    // Start at 0:00 from IDLE
    pulse_start();
`ifdef QUICK_START_EN
    check_eq("quick_digits", disp(), 12'h030);
    check_eq("quick_mag", {11'd0, MagnetronOn}, 12'h001);
    pulse_clear();
`else
    check_eq("zero_start_digits", disp(), 12'h000);
    check_eq("zero_start_mag", {11'd0, MagnetronOn}, 12'h000);
`endif

    // 1:30 countdown with borrow through 1:00
    key(4'd1); key(4'd3); key(4'd0);
    check_eq("entry_130", disp(), 12'h130);
    pulse_start();
    check_eq("run_mag", {11'd0, MagnetronOn}, 12'h001);
    cyc(3);
    check_eq("pre_first_dec", disp(), 12'h130);
    cyc(1);
    check_eq("first_dec", disp(), 12'h129);
    cyc(116);
    check_eq("at_100", disp(), 12'h100);
    cyc(4);
    check_eq("borrow_059", disp(), 12'h059);
    pulse_clear();
    check_eq("clear_run_digits", disp(), 12'h000);
    check_eq("clear_run_mag", {11'd0, MagnetronOn}, 12'h000);

    // 0:02 to DONE
    key(4'd0); key(4'd0); key(4'd2);
    pulse_start();
    cyc(7);
    check_eq("pre_done_digits", disp(), 12'h001);
    check_eq("pre_done_flag", {11'd0, Done}, 12'h000);
    cyc(1);
    check_eq("done_flag", {11'd0, Done}, 12'h001);
    check_eq("done_mag", {11'd0, MagnetronOn}, 12'h000);
    check_eq("done_digits", disp(), 12'h000);
    cyc(5);
    check_eq("done_sticky", {11'd0, Done}, 12'h001);
    key(4'd5);
    check_eq("done_key_exit", {11'd0, Done}, 12'h000);
    check_eq("done_key_digits", disp(), 12'h000);

    // Pause on door open, resume with held prescaler
    key(4'd0); key(4'd1); key(4'd0);
    pulse_start();
    cyc(2);
    DoorClosed = 1'b0;
    cyc(1);
    check_eq("door_pause_mag", {11'd0, MagnetronOn}, 12'h000);
    check_eq("door_pause_digits", disp(), 12'h010);
    cyc(5);
    check_eq("pause_hold", disp(), 12'h010);
    DoorClosed = 1'b1;
    pulse_start();
    check_eq("resume_mag", {11'd0, MagnetronOn}, 12'h001);
    cyc(1);
    check_eq("resume_1cyc", disp(), 12'h010);
    cyc(1);
    check_eq("resume_2cyc", disp(), 12'h009);
    pulse_clear();

    // Key entry rules
    key(4'd1); key(4'd7);
    check_eq("entry_017", disp(), 12'h017);
    key(4'd5);
    check_eq("tens_guard", disp(), 12'h017);
    key(4'd12);
    check_eq("bad_digit", disp(), 12'h017);
    pulse_clear();
    check_eq("clear_idle", disp(), 12'h000);
    key(4'd3); key(4'd12);
    check_eq("bad_digit_low", disp(), 12'h003);
    pulse_clear();

    // Start with door open, Start+Stop in RUN, reset in RUN
    key(4'd4); key(4'd5);
    DoorClosed = 1'b0;
    pulse_start();
    check_eq("door_open_start", {11'd0, MagnetronOn}, 12'h000);
    DoorClosed = 1'b1;
    pulse_start();
    check_eq("run2_mag", {11'd0, MagnetronOn}, 12'h001);
    Start = 1'b1;
    Stop  = 1'b1;
    cyc(1);
    Start = 1'b0;
    Stop  = 1'b0;
    check_eq("start_stop_pause", {11'd0, MagnetronOn}, 12'h000);
    check_eq("start_stop_digits", disp(), 12'h045);
    pulse_start();
    check_eq("run3_mag", {11'd0, MagnetronOn}, 12'h001);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_eq("rst_run_mag", {11'd0, MagnetronOn}, 12'h000);
    check_eq("rst_run_digits", disp(), 12'h000);
    check_eq("rst_run_done", {11'd0, Done}, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
